// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the forwarding/stall unit: RV32 opcode classes,
// operand-usage decode helpers and the in-flight tracker entry layout.
package hazard_fwd_unit_pkg;

    localparam logic [6:0] OPC_NOOP   = 7'b0000000;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Wide enough for any legal LOAD_LATENCY; checked at elaboration by the top.
    localparam int LAT_W = 4;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic [LAT_W-1:0] lat;
    } trk_entry_t;

    function automatic logic has_rd(input logic [6:0] opc);
        return !(opc inside {OPC_BRANCH, OPC_STORE, OPC_NOOP});
    endfunction

    function automatic logic has_rs1(input logic [6:0] opc);
        return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_NOOP});
    endfunction

    function automatic logic has_rs2(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_BRANCH, OPC_STORE};
    endfunction

    function automatic logic is_load(input logic [6:0] opc);
        return opc == OPC_LOAD;
    endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Shift register of in-flight destination registers; entry k was issued k
// cycles ago and its lat field counts down to the cycle its result is usable.
module hazard_tracker
    import hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic                          ins_valid,
    input  logic [4:0]                    ins_rd,
    input  logic [LAT_W-1:0]              ins_lat,
    output trk_entry_t [NUM_STAGES:1]     entries
);

    // NOTE: sequential state uses non-blocking assignments so every entry
    // shifts from its pre-edge neighbour, never from a value updated this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else if (!hold) begin
            entries[1] <= '{valid: ins_valid,
                            rd:    ins_valid ? ins_rd  : 5'd0,
                            lat:   ins_valid ? ins_lat : '0};
            for (int k = 2; k <= NUM_STAGES; k++) begin
                entries[k] <= '{valid: entries[k-1].valid,
                                rd:    entries[k-1].rd,
                                lat:   (entries[k-1].lat != '0) ? entries[k-1].lat - 1'b1 : '0};
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-side hazard unit: per-source forward selects, load-use stall request
// and a saturating stall-cycle counter, driven by an in-flight rd tracker.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_STAGES   = 2,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 32,
    parameter int SEL_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_d,
    input  logic             inst_d_valid,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel_rs1,
    output logic [SEL_W-1:0] fwd_sel_rs2,
    output logic [CNT_W-1:0] stall_count
);

    if (LOAD_LATENCY >= NUM_STAGES || LOAD_LATENCY >= 2**LAT_W) begin : g_bad_cfg
        $error("hazard_fwd_unit: LOAD_LATENCY must be below NUM_STAGES");
    end

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       use_rs1, use_rs2;
    logic       unused_inst_bits;

    assign opcode  = inst_d[6:0];
    assign rd      = inst_d[11:7];
    assign rs1     = inst_d[19:15];
    assign rs2     = inst_d[24:20];
    assign use_rs1 = inst_d_valid && has_rs1(opcode) && (rs1 != 5'd0);
    assign use_rs2 = inst_d_valid && has_rs2(opcode) && (rs2 != 5'd0);
    assign unused_inst_bits = ^{inst_d[31:25], inst_d[14:12]};

    trk_entry_t [NUM_STAGES:1] entries;
    logic [SEL_W-1:0]          sel_rs1, sel_rs2;
    logic                      busy_rs1, busy_rs2, stall_raw;
    logic                      flush_pend, squash, ins_valid;

    // Scan oldest to youngest so the youngest matching producer is left standing.
    always_comb begin
        sel_rs1  = '0;
        sel_rs2  = '0;
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (use_rs1 && entries[k].valid && entries[k].rd == rs1) begin
                sel_rs1  = SEL_W'(k);
                busy_rs1 = (entries[k].lat != '0);
            end
            if (use_rs2 && entries[k].valid && entries[k].rd == rs2) begin
                sel_rs2  = SEL_W'(k);
                busy_rs2 = (entries[k].lat != '0);
            end
        end
    end

    assign stall_raw   = busy_rs1 || busy_rs2;
    assign stall       = !rst && stall_raw;
    assign fwd_sel_rs1 = rst ? '0 : sel_rs1;
    assign fwd_sel_rs2 = rst ? '0 : sel_rs2;

    // A flush seen during a hold is remembered and applied on release.
    assign squash    = (flush || flush_pend) && !pipe_hold;
    assign ins_valid = inst_d_valid && has_rd(opcode) && (rd != 5'd0) && !stall_raw && !squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend  <= 1'b0;
            stall_count <= '0;
        end else begin
            flush_pend <= pipe_hold && (flush_pend || flush);
            if (stall_raw && !pipe_hold && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    hazard_tracker #(
        .NUM_STAGES (NUM_STAGES)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .hold      (pipe_hold),
        .ins_valid (ins_valid),
        .ins_rd    (rd),
        .ins_lat   (is_load(opcode) ? LAT_W'(LOAD_LATENCY) : '0),
        .entries   (entries)
    );

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised forwarding-select and load-use stall unit for the integer pipeline, generalising the single-stage rs2 bypass detector to both sources and a configurable number of in-flight stages. It sits beside decode/execute: each cycle it compares the decode-stage instruction's rs1/rs2 against a tracker of in-flight destination registers. From that comparison it emits per-source forward selects, a stall request when the youngest producer's data is not yet available (load-use), and a saturating stall counter.

## Interface
- NUM_STAGES, 2, in-flight stages tracked after decode; entry k is the instruction issued k cycles ago (1..NUM_STAGES)
- LOAD_LATENCY, 1, cycles a load's result lags a normal result; legal range 0..NUM_STAGES-1
- CNT_W, 32, stall counter width
- SEL_W, $clog2(NUM_STAGES+1), forward-select width (derived; not overridden)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- inst_d  in  32  instruction in decode
- inst_d_valid  in  1  inst_d is a real instruction; 0 is treated as a bubble
- pipe_hold  in  1  whole-pipeline freeze (e.g. memory wait)
- flush  in  1  squash the decode instruction (taken branch/jump)
- stall  out  1  hold PC/decode and inject a bubble
- fwd_sel_rs1  out  SEL_W  0 = register file, k = forward from entry k
- fwd_sel_rs2  out  SEL_W  same encoding, for rs2
- stall_count  out  CNT_W  saturating count of cycles with stall=1 and pipe_hold=0

## Operation
- Decode classes:
  - has_rd is false for BRANCH, STORE and NOOP opcodes.
  - has_rs1 is false for LUI, AUIPC, JAL and NOOP.
  - has_rs2 is true only for R-type, BRANCH and STORE.
  - is_load is true for the LOAD opcode.
- Tracker entry: {valid, rd[4:0], lat}.
- Insert rule:
  - An instruction is inserted at entry 1 when it is valid, has_rd, rd≠x0, not stalled and not squashed.
  - On insert, lat = LOAD_LATENCY if is_load, else 0.
  - Otherwise a bubble (valid=0) is inserted.
- Shift: each non-hold cycle, entry k moves to k+1 and lat decrements, saturating at 0. Entry NUM_STAGES is discarded; its value is in the register file.
- Match: source s matches entry k when entry valid, rd==s, s≠x0, and the source is used. The youngest (lowest k) match wins.
- fwd_sel = k of the winning match, else 0.
- stall = 1 if any used source's winning match has lat≠0.
- When stall=1, fwd_sel is still driven but is don't-care to execute.
- Squash:
  - flush with pipe_hold=0 squashes the current decode instruction.
  - flush with pipe_hold=1 sets flush_pend. The squash is then applied on the first cycle with pipe_hold=0, and flush_pend is cleared.
- Hold: pipe_hold=1 freezes the tracker, lat values and the counter. Outputs remain combinationally valid.
- x0 never matches any entry.

## Timing
- fwd_sel and stall are combinational from inst_d and tracker state (same cycle). The tracker updates on the clock edge.
- NUM_STAGES=2, LOAD_LATENCY=1:
  - A load issued at cycle t with a dependent instruction at t+1 gives stall=1 for one cycle.
  - At t+2 the output is fwd_sel=2, stall=0.
- Reset:
  - All entries invalid and lat=0, flush_pend=0, stall_count=0.
  - While rst=1, stall=0 and both fwd_sel=0 regardless of inputs.
- Reset mid-stall: the cycle after rst deasserts, no stall, all selects 0.
- stall_count saturates at 2^CNT_W−1 and does not wrap.

## Structure
- Shared package holds:
  - opcode constants (extending the existing Opcode definitions)
  - decode functions has_rd/has_rs1/has_rs2/is_load
  - tracker entry struct typedef
- One sub-module, hazard_tracker: the NUM_STAGES-deep shift register with lat countdown, hold and bubble insertion.
- Top level holds:
  - decode
  - per-source priority match
  - flush_pend
  - counter
- Elaboration check: LOAD_LATENCY < NUM_STAGES.

## Test plan
All scenarios run with NUM_STAGES=2, LOAD_LATENCY=1.
- ALU RAW: add x5,x1,x2 then add x6,x5,x5 next cycle -> fwd_sel_rs1=fwd_sel_rs2=1, stall=0. One cycle later, sw x5,0(x6) -> fwd_sel_rs2=2, fwd_sel_rs1=1.
- Load-use: lw x7,0(x1) then add x8,x7,x0 -> stall=1 for exactly one cycle, then fwd_sel_rs1=2. stall_count=1.
- x0 and no-rd producers: add x0,x1,x2 or beq x3,x4 followed by a reader of x0/x3 -> selects 0, no stall.
- Priority: add x9 at t, add x9 at t+1, reader at t+2 -> fwd_sel_rs1=1 (youngest producer).
- Hold/flush: lw x7, then pipe_hold=1 for 3 cycles with a dependent instruction in decode, and flush pulsed on hold cycle 2 ->
  - stall stays 1 and stall_count stays unchanged during the hold;
  - after release, the flushed instruction enters the tracker as a bubble.
- Reset mid-stall: assert rst during the load-use stall -> next cycle stall=0, selects 0, stall_count=0. A reader of x7 afterwards gets fwd_sel=0.
